eq_step_ctrl: RTL and testbench

EQ_STEP_CTRL -- requirements
Module: eq_step_ctrl

---
 rtl/eq_step_ctrl.sv | 140 ++++++++++++++
 tb/tb_eq_step_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_step_ctrl.sv
// Lock-step equivalence controller: steps a spec and an impl model, lets the
// impl drain after it completes, then compares the masked output channels once.
module eq_step_ctrl #(
  parameter int unsigned    DATA_W    = 8,
  parameter int unsigned    NCH       = 2,
  parameter int unsigned    DRAIN_CYC = 6,
  parameter int unsigned    MAX_CYC   = 15,
  parameter logic [NCH-1:0] CMP_MASK  = '1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  spec_complete,
  input  logic                  impl_complete,
  input  logic [NCH*DATA_W-1:0] spec_data,
  input  logic [NCH-1:0]        spec_valid,
  input  logic [NCH*DATA_W-1:0] impl_data,
  input  logic [NCH-1:0]        impl_valid,
  output logic                  spec_step,
  output logic                  impl_step,
  output logic [1:0]            phase,
  output logic [15:0]           cycle_cnt,
  output logic [7:0]            drain_cnt,
  output logic [NCH-1:0]        mismatch_ch,
  output logic                  eq_ok,
  output logic                  timeout
);

  localparam logic [7:0]  DRAIN_LIM = 8'(DRAIN_CYC);
  localparam logic [15:0] MAX_LIM   = 16'(MAX_CYC);

  typedef enum logic [1:0] {
    PH_RUN   = 2'd0,
    PH_CHECK = 2'd1,
    PH_DONE  = 2'd2
  } phase_e;

  phase_e         state_q, state_d;
  logic [15:0]    cyc_q, cyc_d;
  logic [7:0]     drain_q, drain_d;
  logic [NCH-1:0] mis_q, mis_d;
  logic           eq_q, eq_d;
  logic           to_q, to_d;

  logic           run;
  logic           drain_open;
  logic [NCH-1:0] mis_cmp;
  logic [DATA_W-1:0] sd, id;

  assign run        = (state_q == PH_RUN);
  assign drain_open = (drain_q < DRAIN_LIM);

  // Step enables are combinational and held off while reset is asserted
  assign spec_step = ap_rst_n & run & ~spec_complete;
  assign impl_step = ap_rst_n & run & drain_open;

  assign phase       = state_q;
  assign cycle_cnt   = cyc_q;
  assign drain_cnt   = drain_q;
  assign mismatch_ch = mis_q;
  assign eq_ok       = eq_q;
  assign timeout     = to_q;

  // Per-channel compare: valid disagreement, or both valid with differing data
  always_comb begin
    mis_cmp = '0;
    sd      = '0;
    id      = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      sd = spec_data[k*DATA_W +: DATA_W];
      id = impl_data[k*DATA_W +: DATA_W];
      mis_cmp[k] = CMP_MASK[k] &
                   ((spec_valid[k] ^ impl_valid[k]) |
                    (spec_valid[k] & impl_valid[k] & (sd != id)));
    end
  end

  // Next-state and next-output logic for the RUN/CHECK/DONE sequence
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    mis_d   = mis_q;
    eq_d    = eq_q;
    to_d    = to_q;

    // Drain counter tracks impl_complete in every phase
    if (!impl_complete) begin
      drain_d = 8'd0;
    end else if (drain_open) begin
      drain_d = drain_q + 8'd1;
    end else begin
      drain_d = drain_q;
    end

    case (state_q)
      PH_RUN: begin
        if (cyc_q < MAX_LIM) begin
          cyc_d = cyc_q + 16'd1;
        end
        // Completion wins over a simultaneous timeout
        if (spec_complete && !drain_open) begin
          state_d = PH_CHECK;
        end else if (cyc_q == MAX_LIM) begin
          state_d = PH_DONE;
          to_d    = 1'b1;
        end
      end
      PH_CHECK: begin
        mis_d   = mis_cmp;
        eq_d    = (mis_cmp == '0) && !to_q;
        state_d = PH_DONE;
      end
      PH_DONE: begin
        state_d = PH_DONE;
      end
      default: begin
        state_d = PH_RUN;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= PH_RUN;
      cyc_q   <= 16'd0;
      drain_q <= 8'd0;
      mis_q   <= '0;
      eq_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      drain_q <= drain_d;
      mis_q   <= mis_d;
      eq_q    <= eq_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_eq_step_ctrl.sv
// Randomized and directed bench for eq_step_ctrl against a cycle-level
// behavioural model; two instances cover full and partial compare masks.
module tb_eq_step_ctrl;

  localparam int DRAIN = 6;
  localparam int MAXC  = 15;

  logic        clk;
  logic        ap_rst_n;
  logic        spec_complete, impl_complete;
  logic [15:0] spec_data, impl_data;
  logic [1:0]  spec_valid, impl_valid;

  logic        a_ss, a_is, a_eq, a_to;
  logic [1:0]  a_ph, a_mm;
  logic [15:0] a_cc;
  logic [7:0]  a_dc;
  logic        b_ss, b_is, b_eq, b_to;
  logic [1:0]  b_ph, b_mm;
  logic [15:0] b_cc;
  logic [7:0]  b_dc;

  eq_step_ctrl u_dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n),
    .spec_complete(spec_complete), .impl_complete(impl_complete),
    .spec_data(spec_data), .spec_valid(spec_valid),
    .impl_data(impl_data), .impl_valid(impl_valid),
    .spec_step(a_ss), .impl_step(a_is), .phase(a_ph), .cycle_cnt(a_cc),
    .drain_cnt(a_dc), .mismatch_ch(a_mm), .eq_ok(a_eq), .timeout(a_to)
  );

  eq_step_ctrl #(.CMP_MASK(2'b10)) u_dut_m (
    .ap_clk(clk), .ap_rst_n(ap_rst_n),
    .spec_complete(spec_complete), .impl_complete(impl_complete),
    .spec_data(spec_data), .spec_valid(spec_valid),
    .impl_data(impl_data), .impl_valid(impl_valid),
    .spec_step(b_ss), .impl_step(b_is), .phase(b_ph), .cycle_cnt(b_cc),
    .drain_cnt(b_dc), .mismatch_ch(b_mm), .eq_ok(b_eq), .timeout(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus held by the caller, driven onto the pins each cycle
  logic [7:0] tsd [2];
  logic [7:0] tid [2];
  logic [1:0] tsv, tiv;
  logic [1:0] masks [2];

  // Reference model state (phase: 0 run, 1 check, 2 done)
  int m_phase, m_cyc, m_drain, m_to;
  int m_mis [2];
  int m_eq  [2];
  int cap_is;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cyc = 0; m_drain = 0; m_to = 0;
    for (int i = 0; i < 2; i++) begin
      m_mis[i] = 0;
      m_eq[i]  = 0;
    end
  endtask

  // One clock cycle: drive, compare all outputs of both instances, advance model
  task automatic run_cycle(input logic rst, input logic sc, input logic ic);
    int ss, is, n_phase, n_cyc, n_drain, n_to, mis, bad;
    int n_mis [2];
    int n_eq  [2];
    @(negedge clk);
    ap_rst_n      = rst;
    spec_complete = sc;
    impl_complete = ic;
    spec_data     = {tsd[1], tsd[0]};
    impl_data     = {tid[1], tid[0]};
    spec_valid    = tsv;
    impl_valid    = tiv;
    #1;
    ss = (rst && m_phase == 0 && !sc) ? 1 : 0;
    is = (rst && m_phase == 0 && m_drain < DRAIN) ? 1 : 0;
    cap_is = int'(a_is);
    chk("spec_step",   int'(a_ss), ss);
    chk("impl_step",   int'(a_is), is);
    chk("phase",       int'(a_ph), m_phase);
    chk("cycle_cnt",   int'(a_cc), m_cyc);
    chk("drain_cnt",   int'(a_dc), m_drain);
    chk("mismatch",    int'(a_mm), m_mis[0]);
    chk("eq_ok",       int'(a_eq), m_eq[0]);
    chk("timeout",     int'(a_to), m_to);
    chk("m_spec_step", int'(b_ss), ss);
    chk("m_impl_step", int'(b_is), is);
    chk("m_phase",     int'(b_ph), m_phase);
    chk("m_cycle_cnt", int'(b_cc), m_cyc);
    chk("m_mismatch",  int'(b_mm), m_mis[1]);
    chk("m_eq_ok",     int'(b_eq), m_eq[1]);
    chk("m_timeout",   int'(b_to), m_to);

    n_phase = m_phase; n_cyc = m_cyc; n_to = m_to;
    n_drain = ic ? ((m_drain < DRAIN) ? m_drain + 1 : m_drain) : 0;
    for (int i = 0; i < 2; i++) begin
      n_mis[i] = m_mis[i];
      n_eq[i]  = m_eq[i];
    end
    if (m_phase == 0) begin
      n_cyc = (m_cyc < MAXC) ? m_cyc + 1 : MAXC;
      if (sc && !is) n_phase = 1;
      else if (m_cyc == MAXC) begin
        n_phase = 2;
        n_to    = 1;
      end
    end else if (m_phase == 1) begin
      for (int i = 0; i < 2; i++) begin
        mis = 0;
        for (int k = 0; k < 2; k++) begin
          bad = (tsv[k] != tiv[k]) || (tsv[k] && tiv[k] && tsd[k] != tid[k]);
          if (masks[i][k] && bad) mis += (1 << k);
        end
        n_mis[i] = mis;
        n_eq[i]  = (mis == 0 && m_to == 0) ? 1 : 0;
      end
      n_phase = 2;
    end
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      m_phase = n_phase; m_cyc = n_cyc; m_drain = n_drain; m_to = n_to;
      for (int i = 0; i < 2; i++) begin
        m_mis[i] = n_mis[i];
        m_eq[i]  = n_eq[i];
      end
    end
  endtask

  task automatic set_equal_data();
    tsd[0] = 8'h11; tid[0] = 8'h11;
    tsd[1] = 8'h5B; tid[1] = 8'h5B;
    tsv = 2'b11; tiv = 2'b11;
  endtask

  task automatic do_reset();
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Standard run: impl completes from cycle 3, spec from cycle 5
  task automatic std_run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      run_cycle(1'b1, logic'(c >= 5), logic'(c >= 3));
      #1;
      if (c == 8)  chk("drain_at_9", int'(a_dc), 6);
      if (c == 9)  chk("impl_step_low_9", cap_is, 0);
      if (c == 9)  chk("check_at_10", int'(a_ph), 1);
      if (c == 10) chk("done_at_11", int'(a_ph), 2);
    end
  endtask

  initial begin
    int ts, ti, sc_mode, ic_mode;
    logic rst, sc, ic;
    masks[0] = 2'b11;
    masks[1] = 2'b10;
    model_reset();
    set_equal_data();
    ap_rst_n = 1'b0; spec_complete = 1'b0; impl_complete = 1'b0;
    spec_data = '0; impl_data = '0; spec_valid = '0; impl_valid = '0;

    // Reset values, then matching data completes cleanly
    do_reset();
    #1;
    chk("rst_phase", int'(a_ph), 0);
    chk("rst_cycle", int'(a_cc), 0);
    std_run(14);
    chk("eq_match", int'(a_eq), 1);
    chk("mm_match", int'(a_mm), 0);

    // Data mismatch on channel 1
    do_reset();
    set_equal_data();
    tid[1] = 8'h5A;
    std_run(14);
    chk("mm_ch1", int'(a_mm), 2);
    chk("eq_ch1", int'(a_eq), 0);

    // Valid disagreement on a masked-out channel
    do_reset();
    set_equal_data();
    tsv = 2'b01; tiv = 2'b00;
    std_run(14);
    chk("masked_mm", int'(b_mm), 0);
    chk("masked_eq", int'(b_eq), 1);
    chk("full_mm",   int'(a_mm), 1);

    // Neither side completes: timeout
    do_reset();
    set_equal_data();
    for (int c = 0; c < 20; c++) run_cycle(1'b1, 1'b0, 1'b0);
    #1;
    chk("to_cycle", int'(a_cc), MAXC);
    chk("to_phase", int'(a_ph), 2);
    chk("to_flag",  int'(a_to), 1);
    chk("to_eq",    int'(a_eq), 0);
    chk("to_ss",    int'(a_ss), 0);

    // Pulsed impl_complete restarts drain
    do_reset();
    run_cycle(1'b1, 1'b0, 1'b1); #1; chk("pulse_d1", int'(a_dc), 1);
    run_cycle(1'b1, 1'b0, 1'b1); #1; chk("pulse_d2", int'(a_dc), 2);
    run_cycle(1'b1, 1'b0, 1'b0); #1; chk("pulse_d0", int'(a_dc), 0);
    run_cycle(1'b1, 1'b0, 1'b1); #1; chk("pulse_d1b", int'(a_dc), 1);
    chk("pulse_istep", int'(a_is), 1);

    // Reset during CHECK discards the comparison, then a fresh run
    do_reset();
    set_equal_data();
    tid[0] = 8'h00;
    for (int c = 0; c < 10; c++) run_cycle(1'b1, logic'(c >= 5), logic'(c >= 3));
    #1;
    chk("pre_rst_check", int'(a_ph), 1);
    run_cycle(1'b0, 1'b1, 1'b1);
    #1;
    chk("midrst_phase", int'(a_ph), 0);
    chk("midrst_cycle", int'(a_cc), 0);
    chk("midrst_mm",    int'(a_mm), 0);
    set_equal_data();
    std_run(14);
    chk("rerun_eq", int'(a_eq), 1);

    // Randomized episodes with occasional mid-run resets
    for (int e = 0; e < 40; e++) begin
      do_reset();
      ts = int'($urandom_range(0, 16));
      ti = int'($urandom_range(0, 12));
      sc_mode = int'($urandom_range(0, 2));
      ic_mode = int'($urandom_range(0, 2));
      for (int k = 0; k < 2; k++) begin
        tsd[k] = 8'($urandom);
        tid[k] = ($urandom_range(0, 1) == 0) ? tsd[k] : 8'($urandom);
      end
      tsv = 2'($urandom);
      tiv = ($urandom_range(0, 1) == 0) ? tsv : 2'($urandom);
      for (int c = 0; c < 26; c++) begin
        rst = logic'($urandom_range(0, 39) != 0);
        sc  = logic'(c >= ts && (sc_mode != 0 || $urandom_range(0, 3) != 0));
        ic  = logic'(c >= ti && (ic_mode != 0 || $urandom_range(0, 4) != 0));
        if (sc_mode == 2 && ts > 14) sc = 1'b0;
        run_cycle(rst, sc, ic);
        if ($urandom_range(0, 7) == 0) tsd[0] = 8'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
